config_chain_segment: RTL and testbench
=======================================

// Module: config_chain_segment
// PURPOSE
//  Fabric-side consumer of the Wishbone configuration port's cen / set_out / shift_out outputs.
//  Holds LANES serial config shift registers of CHAIN_LEN bits each.
//  A set strobe commits each shift register into a shadow register that drives tile config bits.
//  Forwards shift/set to the next segment, so segments daisy-chain across the fabric.
// PARAMETERS
//  CHAIN_LEN  64  config bits per lane in this segment (>=2)
//  LANES      4   parallel chains; matches 4-bit shift/set bus of the config port
//  CNT_W      $clog2(CHAIN_LEN+1)  localparam, bit-counter width
// PORTS
//  wb_clk_i   in   1                  single clock for the whole block
//  wb_rst_i   in   1                  synchronous, active-high reset
//  cen        in   1                  shift enable; one bit per lane shifted per cycle when 1
//  shift_in   in   LANES              serial data, one bit per lane
//  set_in     in   LANES              per-lane commit strobe (level; rising edge acts)
//  shift_out  out  LANES              sr[l][CHAIN_LEN-1], feeds next segment's shift_in
//  set_out    out  LANES              set_in delayed 1 cycle, feeds next segment
//  cfg_out    out  LANES*CHAIN_LEN    shadow config; lane l at [l*CHAIN_LEN +: CHAIN_LEN]
//  cfg_valid  out  LANES              lane has committed at least once since reset
//  len_err    out  LANES              last commit saw fewer than CHAIN_LEN shifts
// BEHAVIOUR
//  - Reset (wb_rst_i=1 at clk edge): sr, shadow, cnt, set_q, set_out, cfg_valid, len_err all 0.
//    shift_out = 0 and cfg_out = 0 follow from this.
//    Reset mid-shift discards partial data; no commit occurs in the reset cycle.
//  - Shift: if cen, sr[l] <= {sr[l][CHAIN_LEN-2:0], shift_in[l]} for every lane.
//    The first bit shifted reaches the MSB after CHAIN_LEN shifts.
//    cen=0 freezes sr and cnt; set handling continues.
//  - shift_out is driven straight from the sr MSB flop, with no extra register.
//    Segment latency is exactly CHAIN_LEN enabled cycles.
//  - set_q[l] <= set_in[l]; set_out = set_q. Commit pulse: commit[l] = set_in[l] & ~set_q[l].
//    A strobe held N cycles commits exactly once.
//  - On commit[l]:
//    - shadow[l] <= sr[l], the pre-shift value of the current cycle.
//    - cfg_valid[l] <= 1 (sticky until reset).
//    - len_err[l] per CFG_LEN_CHECK_EN.
//  - Simultaneous commit and cen: the commit captures the pre-shift sr, and the shift still occurs.
//    cnt restarts at 1, because the shifted bit counts toward the next frame.
//  - Lanes are fully independent; commits on different lanes in the same cycle are all honoured.
//  - cfg_out changes only on a commit cycle, never during shifting (glitch-free tile config).
// CONFIGURATION
//  CFG_LEN_CHECK_EN defined:
//  - Per-lane cnt counts enabled shifts since the last commit or reset.
//  - cnt saturates at CHAIN_LEN; extra bits from downstream segments are legal.
//  - On commit: len_err[l] <= (cnt[l] < CHAIN_LEN) and cnt <= (cen ? 1 : 0).
//  - len_err is held until the next commit or reset. The commit always updates shadow, even on error.
//  CFG_LEN_CHECK_EN undefined: no counters are synthesised and len_err is tied to 0.
// TESTING (CHAIN_LEN=8, LANES=4 unless stated; CFG_LEN_CHECK_EN defined)
//  1 Assert reset 2 cycles with random inputs
//    -> all outputs 0 the cycle after the first reset edge, and they stay 0.
//  2 Lane0: cen=1, shift 1,0,1,1,0,0,1,0, then pulse set_in[0]
//    -> cfg_out[7:0]=8'hB2, cfg_valid=4'b0001, len_err=0, set_out[0] 1 cycle after set_in[0].
//  3 Lane1: shift 5 bits then set
//    -> shadow updated to the partial value, len_err[1]=1.
//    -> A following full 8-bit shift plus set clears len_err[1].
//  4 set_in[2] held high 4 cycles with a new frame loaded
//    -> exactly one shadow update; set_out[2] high for 4 cycles, delayed by 1.
//  5 Shift 7 bits; in the next cycle raise cen and set_in[3] together
//    -> shadow gets the 7-bit pre-shift value, len_err[3]=1, internal cnt=1.
//  6 Shift 16 bits into lane0
//    -> shift_out[0] equals the first input bit in the cycle after the 8th shift.
//    -> Two chained instances commit frames 2 and 1 respectively on a shared set.
//    -> Rebuilt without CFG_LEN_CHECK_EN: len_err stays 0 throughout.

Source files
------------

// File: rtl/config_chain_segment.sv
// Fabric-side config chain segment: LANES serial shift registers committed into shadow config on set.
// Optional per-lane shift-length checking is enabled by defining CFG_LEN_CHECK_EN.
module config_chain_segment #(
  parameter int CHAIN_LEN = 64,
  parameter int LANES     = 4
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         cen,
  input  logic [LANES-1:0]             shift_in,
  input  logic [LANES-1:0]             set_in,
  output logic [LANES-1:0]             shift_out,
  output logic [LANES-1:0]             set_out,
  output logic [LANES*CHAIN_LEN-1:0]   cfg_out,
  output logic [LANES-1:0]             cfg_valid,
  output logic [LANES-1:0]             len_err
);

  logic [LANES-1:0][CHAIN_LEN-1:0] sr_q, sr_d;
  logic [LANES-1:0][CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [LANES-1:0]                set_q;
  logic [LANES-1:0]                valid_q, valid_d;
  logic [LANES-1:0]                commit;

  // Commit captures the pre-shift register, so a shift in the same cycle belongs to the next frame.
  always_comb begin
    commit   = set_in & ~set_q;
    sr_d     = sr_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    for (int l = 0; l < LANES; l++) begin
      if (commit[l]) begin
        shadow_d[l] = sr_q[l];
        valid_d[l]  = 1'b1;
      end
      if (cen) begin
        sr_d[l] = {sr_q[l][CHAIN_LEN-2:0], shift_in[l]};
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sr_q     <= '0;
      shadow_q <= '0;
      set_q    <= '0;
      valid_q  <= '0;
    end else begin
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      set_q    <= set_in;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    shift_out = '0;
    for (int l = 0; l < LANES; l++) begin
      shift_out[l] = sr_q[l][CHAIN_LEN-1];
    end
  end

  assign set_out   = set_q;
  assign cfg_out   = shadow_q;
  assign cfg_valid = valid_q;

`ifdef CFG_LEN_CHECK_EN
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  logic [LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0]            len_err_q, len_err_d;

  // Counter saturates at a full frame; surplus bits are destined for downstream segments.
  always_comb begin
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    for (int l = 0; l < LANES; l++) begin
      if (commit[l]) begin
        len_err_d[l] = (cnt_q[l] < CNT_FULL);
        cnt_d[l]     = cen ? CNT_W'(1) : '0;
      end else if (cen && (cnt_q[l] < CNT_FULL)) begin
        cnt_d[l] = cnt_q[l] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q     <= '0;
      len_err_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = '0;
`endif

endmodule

// File: tb/tb_config_chain_segment.sv
// Scoreboard bench for two daisy-chained config_chain_segment instances (CHAIN_LEN=8, LANES=4).
// Reference model keeps a log of shifted bit vectors; segment k holds log entries 8k..8k+7.
module tb_config_chain_segment;

  localparam int CL = 8;
  localparam int LN = 4;

  logic clk = 1'b0;
  logic rst, cen;
  logic [LN-1:0] shIn, setIn;

  logic [LN-1:0]    so0, setOut0, valid0, err0;
  logic [LN*CL-1:0] cfg0;
  logic [LN-1:0]    so1, setOut1, valid1, err1;
  logic [LN*CL-1:0] cfg1;

  always #5 clk = ~clk;

  config_chain_segment #(.CHAIN_LEN(CL), .LANES(LN)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cen(cen),
    .shift_in(shIn), .set_in(setIn),
    .shift_out(so0), .set_out(setOut0), .cfg_out(cfg0),
    .cfg_valid(valid0), .len_err(err0)
  );

  config_chain_segment #(.CHAIN_LEN(CL), .LANES(LN)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cen(cen),
    .shift_in(so0), .set_in(setOut0),
    .shift_out(so1), .set_out(setOut1), .cfg_out(cfg1),
    .cfg_valid(valid1), .len_err(err1)
  );

  typedef struct packed {
    logic [LN-1:0]    so0, sto0, v0, e0;
    logic [LN*CL-1:0] cfg0;
    logic [LN-1:0]    so1, sto1, v1, e1;
    logic [LN*CL-1:0] cfg1;
  } exp_t;

  exp_t expQ[$];
  int nChecks = 0;
  int nFails  = 0;

  logic [LN-1:0] histQ[$];
  logic [CL-1:0] shadow0[LN], shadow1[LN];
  logic [LN-1:0] mValid0, mValid1, mErr0, mErr1, setPrev0, setPrev1;
  int            cnt0[LN], cnt1[LN];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic histBit(input int idx, input int lane);
    if (idx < histQ.size()) return histQ[idx][lane];
    return 1'b0;
  endfunction

  function automatic logic [CL-1:0] segVal(input int lane, input int seg);
    logic [CL-1:0] v = '0;
    for (int i = 0; i < CL; i++) v[i] = histBit(seg*CL + i, lane);
    return v;
  endfunction

  // Advance the model across one clock edge and return the outputs expected after it.
  function automatic exp_t modelStep(input logic r, input logic c, input logic [LN-1:0] sh,
                                     input logic [LN-1:0] st);
    exp_t e;
    logic [LN-1:0] set1, commit0, commit1;
    if (r) begin
      histQ.delete();
      for (int l = 0; l < LN; l++) begin
        shadow0[l] = '0; shadow1[l] = '0; cnt0[l] = 0; cnt1[l] = 0;
      end
      mValid0 = '0; mValid1 = '0; mErr0 = '0; mErr1 = '0; setPrev0 = '0; setPrev1 = '0;
    end else begin
      set1    = setPrev0;
      commit0 = st & ~setPrev0;
      commit1 = set1 & ~setPrev1;
      for (int l = 0; l < LN; l++) begin
        if (commit0[l]) begin
          shadow0[l] = segVal(l, 0); mValid0[l] = 1'b1;
          mErr0[l] = (cnt0[l] < CL); cnt0[l] = c ? 1 : 0;
        end else if (c) cnt0[l]++;
        if (commit1[l]) begin
          shadow1[l] = segVal(l, 1); mValid1[l] = 1'b1;
          mErr1[l] = (cnt1[l] < CL); cnt1[l] = c ? 1 : 0;
        end else if (c) cnt1[l]++;
      end
      if (c) begin
        histQ.push_front(sh);
        if (histQ.size() > 2*CL) void'(histQ.pop_back());
      end
      setPrev1 = set1;
      setPrev0 = st;
    end
    for (int l = 0; l < LN; l++) begin
      e.so0[l] = histBit(CL-1, l);
      e.so1[l] = histBit(2*CL-1, l);
      e.cfg0[l*CL +: CL] = shadow0[l];
      e.cfg1[l*CL +: CL] = shadow1[l];
    end
    e.sto0 = setPrev0;
    e.sto1 = setPrev1;
    e.v0 = mValid0;
    e.v1 = mValid1;
`ifdef CFG_LEN_CHECK_EN
    e.e0 = mErr0;
    e.e1 = mErr1;
`else
    e.e0 = '0;
    e.e1 = '0;
`endif
    return e;
  endfunction

  task automatic applyStimulus(input logic r, input logic c, input logic [LN-1:0] sh,
                               input logic [LN-1:0] st);
    exp_t e;
    rst = r; cen = c; shIn = sh; setIn = st;
    e = modelStep(r, c, sh, st);
    @(posedge clk);
    #1;
    expQ.push_back(e);
  endtask

  // Shift n bits of val (MSB first) into one lane; other lanes receive random bits.
  task automatic shiftFrame(input int lane, input logic [15:0] val, input int n);
    logic [LN-1:0] sh;
    for (int i = n-1; i >= 0; i--) begin
      sh = LN'($urandom);
      sh[lane] = val[i];
      applyStimulus(1'b0, 1'b1, sh, '0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("shift_out0", 32'(so0), 32'(e.so0));
      checkOutput("set_out0", 32'(setOut0), 32'(e.sto0));
      checkOutput("cfg_out0", cfg0, e.cfg0);
      checkOutput("cfg_valid0", 32'(valid0), 32'(e.v0));
      checkOutput("len_err0", 32'(err0), 32'(e.e0));
      checkOutput("shift_out1", 32'(so1), 32'(e.so1));
      checkOutput("set_out1", 32'(setOut1), 32'(e.sto1));
      checkOutput("cfg_out1", cfg1, e.cfg1);
      checkOutput("cfg_valid1", 32'(valid1), 32'(e.v1));
      checkOutput("len_err1", 32'(err1), 32'(e.e1));
    end
  end

  initial begin
    rst = 1'b1; cen = 1'(($urandom)); shIn = LN'($urandom); setIn = LN'($urandom);
    @(posedge clk);
    #1;
    $display("[TB] reset with random inputs");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'($urandom), LN'($urandom), LN'($urandom));
    applyStimulus(1'b0, 1'b0, '0, '0);

    $display("[TB] lane0 directed frame");
    shiftFrame(0, 16'h00B2, CL);
    applyStimulus(1'b0, 1'b0, LN'($urandom), 4'b0001);
    checkOutput("lane0_frame_B2", 32'(cfg0[7:0]), 32'h0000_00B2);
    checkOutput("lane0_valid_only", 32'(valid0), 32'h1);
    applyStimulus(1'b0, 1'b0, LN'($urandom), 4'b0000);

    $display("[TB] lane1 short frame then full frame");
    shiftFrame(1, 16'($urandom), 5);
    applyStimulus(1'b0, 1'b0, '0, 4'b0010);
    applyStimulus(1'b0, 1'b0, '0, 4'b0000);
    shiftFrame(1, 16'($urandom), CL);
    applyStimulus(1'b0, 1'b0, '0, 4'b0010);
    applyStimulus(1'b0, 1'b0, '0, 4'b0000);

    $display("[TB] lane2 held strobe");
    shiftFrame(2, 16'($urandom), CL);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, LN'($urandom), 4'b0100);
    applyStimulus(1'b0, 1'b0, '0, 4'b0000);
    applyStimulus(1'b0, 1'b0, '0, 4'b0000);

    $display("[TB] lane3 commit coincident with shift");
    shiftFrame(3, 16'($urandom), 7);
    applyStimulus(1'b0, 1'b1, LN'($urandom), 4'b1000);
    shiftFrame(3, 16'($urandom), 7);
    applyStimulus(1'b0, 1'b0, '0, 4'b1000);
    applyStimulus(1'b0, 1'b0, '0, 4'b0000);

    $display("[TB] two-segment chain, 16 bits");
    shiftFrame(0, 16'($urandom), 2*CL);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, '0, 4'b1111);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 4'b0000);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                    LN'($urandom), LN'($urandom & $urandom & $urandom));
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
